// File: rtl/mem_dump_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the memory dump controller.
package mem_dump_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_BASE_ADDR = 32'h48;
  localparam int unsigned DEF_CHIP_ID   = 32'h07;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Index width that stays at least one bit for a single-entry store
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_dump_store.sv
// Storage array with per-entry written flags; one write port, one combinational read port.
module mem_dump_store
  import mem_dump_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned IDX_W  = idx_width(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_written
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  // Data array: contents are qualified by written[], so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Written flags: cleared by reset, set by each stored write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
    end else if (wr_en) begin
      written[wr_idx] <= 1'b1;
    end
  end

  assign rd_data    = mem[rd_idx];
  assign rd_written = written[rd_idx];

endmodule

// File: rtl/mem_dump_ctrl.sv
// Chip-selected write port into a small store plus a single-read / full-dump readout engine.
module mem_dump_ctrl
  import mem_dump_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [6:0]  CHIP_ID   = 7'(DEF_CHIP_ID)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_write,
  input  logic [ADDR_W-1:0]            rw_addr,
  input  logic [7:0]                   cs_addr,
  input  logic [DATA_W-1:0]            input_data,
  input  logic                         an_data,
  input  logic                         en_out,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [ADDR_W-1:0]            out_addr,
  output logic                         out_miss,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   dump_cnt,
  output logic                         wr_err
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t              state;
  logic                dump_mode;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   s_addr;
  logic                s_in_range;

  logic [ADDR_W-1:0]   rw_off_c;
  logic                rw_in_range_c;
  logic                wr_sel_c;
  logic                wr_store_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic                rd_written_c;
  logic                last_idx_c;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic                s_hit_c;

  // Address decode shared by the write port and single-read latch
  assign rw_off_c      = rw_addr - BASE;
  assign rw_in_range_c = (rw_addr >= BASE) && (32'(rw_off_c) < DEPTH);
  assign wr_sel_c      = en_write && (cs_addr[7:1] == CHIP_ID) && !cs_addr[0];
  assign wr_store_c    = wr_sel_c && rw_in_range_c;

  assign last_idx_c = (idx == IDX_W'(DEPTH - 1));
  assign cnt_inc_c  = (cnt == CNT_W'(DEPTH)) ? cnt : cnt + 1'b1;
  assign s_hit_c    = s_in_range && rd_written_c;

  mem_dump_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_store_c),
    .wr_idx     (IDX_W'(rw_off_c)),
    .wr_data    (input_data),
    .rd_idx     (idx),
    .rd_data    (rd_data_c),
    .rd_written (rd_written_c)
  );

  // Out-of-range selected write flags an error on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_sel_c && !rw_in_range_c;
    end
  end

  // Readout FSM with registered beat, status and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dump_mode  <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      s_addr     <= '0;
      s_in_range <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      out_miss   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dump_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en_out) begin
            dump_mode  <= an_data;
            cnt        <= '0;
            // Out-of-range single reads park the index at 0 so the read port stays in bounds
            idx        <= (an_data || !rw_in_range_c) ? '0 : IDX_W'(rw_off_c);
            s_addr     <= rw_addr;
            s_in_range <= rw_in_range_c;
            busy       <= 1'b1;
            state      <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (dump_mode) begin
            if (rd_written_c) begin
              out_data  <= rd_data_c;
              out_addr  <= BASE + ADDR_W'(idx);
              out_miss  <= 1'b0;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end else if (last_idx_c) begin
              done     <= 1'b1;
              dump_cnt <= cnt;
              state    <= ST_FIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            out_data  <= s_hit_c ? rd_data_c : '0;
            out_addr  <= s_addr;
            out_miss  <= !s_hit_c;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= cnt_inc_c;
            if (dump_mode && !last_idx_c) begin
              idx   <= idx + 1'b1;
              state <= ST_SCAN;
            end else begin
              done     <= 1'b1;
              dump_cnt <= cnt_inc_c;
              state    <= ST_FIN;
            end
          end
        end

        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_dump_ctrl.md
MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 Parameters SHALL be as follows:
- DATA_W, default 8, data width.
- ADDR_W, default 8, rw_addr width.
- DEPTH, default 16, number of storage entries.
- BASE_ADDR, default 8'h48, address of entry 0.
- CHIP_ID, default 7'b000_0111, select code compared with cs_addr[7:1].
REQ-002 Ports SHALL be as follows:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_write  in  1  write strobe, one cycle.
- rw_addr  in  ADDR_W  write address, and read address in single mode.
- cs_addr  in  8  chip select; [7:1] is the ID, [0] is 0 for a write.
- input_data  in  DATA_W  write data.
- an_data  in  1  readout mode, sampled with en_out: 0 = single read at rw_addr, 1 = dump of all written entries.
- en_out  in  1  readout start strobe, one cycle.
- out_ready  in  1  sink accepts the current beat.
- out_valid  out  1  beat valid.
- out_data  out  DATA_W  beat data.
- out_addr  out  ADDR_W  absolute address of the beat.
- out_miss  out  1  single-read target unwritten or out of range.
- busy  out  1  readout in progress.
- done  out  1  one-cycle pulse when a readout completes.
- dump_cnt  out  clog2(DEPTH+1)  beats emitted by the last readout.
- wr_err  out  1  one-cycle pulse on a selected write that is out of range.

Function
REQ-003 A write SHALL be selected when all of the following hold: en_write=1, cs_addr[7:1]=CHIP_ID and cs_addr[0]=0.
REQ-004 A selected write with idx=rw_addr-BASE_ADDR in 0..DEPTH-1 SHALL store input_data at idx and set written[idx] on that clock edge.
REQ-005 A selected write with rw_addr<BASE_ADDR or idx>=DEPTH SHALL leave storage unchanged and pulse wr_err in the next cycle.
REQ-006 Writes SHALL be accepted in every state, including during a readout.
REQ-007 The FSM SHALL have the states IDLE, SCAN, HOLD and FIN.
REQ-008 IDLE: en_out=1 SHALL latch an_data, clear the beat counter, set idx=0 in dump mode or latch the rw_addr index in single mode, and move to SCAN; busy SHALL be 1 from the next cycle.
REQ-009 SCAN in dump mode: if written[idx]=1, load out_data/out_addr and go to HOLD; otherwise increment idx. After idx=DEPTH-1 is processed with no beat pending, go to FIN. Each skipped entry costs one cycle.
REQ-010 SCAN in single mode: always go to HOLD. out_miss SHALL be 1 and out_data SHALL be 0 when the target is out of range or unwritten.
REQ-011 HOLD: out_valid=1, and out_data/out_addr/out_miss SHALL stay stable until out_ready=1. On the accepting cycle the beat counter SHALL increment. Dump mode then returns to SCAN with idx+1, or goes to FIN if idx=DEPTH-1; single mode goes to FIN.
REQ-012 FIN: done=1 and dump_cnt is updated for one cycle, then the FSM returns to IDLE with busy=0.
REQ-013 Latency: with en_out at cycle N and entry 0 written, the first out_valid SHALL assert at cycle N+2.
REQ-014 en_out while busy=1 SHALL be ignored.
REQ-015 A write to an index greater than the current idx during a dump SHALL appear in that dump with the new value. A write to an index at or below idx SHALL NOT appear, and the beat in HOLD SHALL keep its captured data.
REQ-016 A dump with no written entries SHALL reach FIN after DEPTH scan cycles with dump_cnt=0.
REQ-017 The beat counter SHALL saturate at DEPTH.

Reset
REQ-018 rst_n=0 SHALL asynchronously force the following, at any time including mid-readout:
- FSM to IDLE.
- written[] cleared.
- out_valid, out_miss, busy, done and wr_err to 0.
- out_data, out_addr and dump_cnt to 0.
- The beat counter and idx to 0.
REQ-019 The storage array contents SHALL NOT require reset; only written[] qualifies them.

Structure
REQ-020 The FSM state encoding and the default DATA_W/ADDR_W/DEPTH/BASE_ADDR/CHIP_ID constants SHALL live in the shared package mem_dump_pkg.
REQ-021 Storage and written[] SHALL be a sub-module mem_dump_store, with one write port and one combinational read port.

Verification
REQ-022 Write 0x55@0x48, 0xAA@0x49 and 0xCC@0x4A with cs_addr=8'h0E, then an_data=1 and en_out with out_ready=1 -> three beats (0x48,0x55), (0x49,0xAA), (0x4A,0xCC), then done with dump_cnt=3.
REQ-023 Same dump with out_ready low for 5 cycles on each beat -> out_valid, out_data and out_addr held stable and identical beats delivered; en_out pulsed mid-dump is ignored.
REQ-024 Write 0x77@0x4B with cs_addr=8'h0F, and write 0x11@0x58 with cs_addr=8'h0E -> no storage change for either; wr_err pulses only for 0x58.
REQ-025 Single read (an_data=0) at 0x49 -> one beat 0xAA with out_miss=0. Single read at 0x50 -> one beat 0x00 with out_miss=1, then done with dump_cnt=1.
REQ-026 During a dump, write 0x99@0x4F while idx<15 -> beat (0x4F,0x99) is emitted. Assert rst_n low while in HOLD -> all outputs are 0 immediately, and a following dump gives dump_cnt=0.
